mdr_mem_unit: RTL

- Parametrised memory data register (MDR) with a built-in memory transaction engine.
- Loads from the internal bus, or runs read/write transactions to memory over a req/ack handshake.
- Supports byte, half and word accesses, with lane steering and sign/zero extension.
- Has a timeout counter that flags an error when memory does not respond; it sits between the datapath bus and the memory port.

---
 rtl/mdr_mem_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mdr_mem_unit.sv
// Memory data register with a req/ack memory transaction engine.
// Handles byte/half/word/dword lane steering, read extension and a response timeout.
module mdr_mem_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned LANES  = WIDTH / 8,
    localparam int unsigned AW     = $clog2(LANES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_mux_out,
    input  logic             mdr_in,
    input  logic             rd_start,
    input  logic             wr_start,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [AW-1:0]    addr_lo,
    output logic [WIDTH-1:0] mdr_q,
    output logic             mem_req,
    output logic             mem_we,
    output logic [LANES-1:0] mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mdr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [LANES-1:0]  mem_be_q, mem_be_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [AW-1:0]     addr_q, addr_d;

    logic              legal_c;
    logic [LANES-1:0]  base_c;
    logic [LANES-1:0]  mask_c;
    logic [WIDTH-1:0]  rep_c;
    logic [WIDTH-1:0]  shifted_c;
    logic [WIDTH-1:0]  ext_c;
    logic              msb_c;
    int                nbits_c;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Alignment check, lane mask and replicated write data for the requested size
    always_comb begin
        legal_c = 1'b0;
        base_c  = '0;
        rep_c   = mdr_q;
        case (size)
            2'b00: begin
                legal_c = 1'b1;
                base_c  = LANES'(1);
                rep_c   = {LANES{mdr_q[7:0]}};
            end
            2'b01: begin
                legal_c = ~addr_lo[0];
                base_c  = LANES'(3);
                rep_c   = {(LANES / 2){mdr_q[15:0]}};
            end
            2'b10: begin
                legal_c = (addr_lo[1:0] == 2'b00);
                base_c  = LANES'(15);
                rep_c   = {(LANES / 4){mdr_q[31:0]}};
            end
            default: begin
                legal_c = (WIDTH == 64) && (addr_lo == '0);
                base_c  = '1;
                rep_c   = mdr_q;
            end
        endcase
        mask_c = base_c << addr_lo;
    end

    // Shift the addressed lanes of read data down to bit 0 and extend
    always_comb begin
        shifted_c = mem_rdata >> {addr_q, 3'b000};
        msb_c     = 1'b0;
        nbits_c   = int'(WIDTH);
        case (size_q)
            2'b00:   begin msb_c = shifted_c[7];  nbits_c = 8;  end
            2'b01:   begin msb_c = shifted_c[15]; nbits_c = 16; end
            2'b10:   begin msb_c = shifted_c[31]; nbits_c = 32; end
            default: begin msb_c = 1'b0;          nbits_c = int'(WIDTH); end
        endcase
        ext_c = shifted_c;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i >= nbits_c) ext_c[i] = sign_q & msb_c;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdr_d       = mdr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        size_d      = size_q;
        sign_d      = sign_q;
        addr_d      = addr_q;
        case (state_q)
            IDLE: begin
                if (rd_start || wr_start) begin
                    if (!legal_c) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_req_d = 1'b1;
                        mem_we_d  = ~rd_start;
                        mem_be_d  = mask_c;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        size_d    = size;
                        sign_d    = sign_ext;
                        addr_d    = addr_lo;
                        if (rd_start) begin
                            state_d = RD_WAIT;
                        end else begin
                            state_d     = WR_WAIT;
                            mem_wdata_d = rep_c;
                        end
                    end
                end else if (mdr_in) begin
                    mdr_d = bus_mux_out;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    if (mem_ack && (state_q == RD_WAIT)) mdr_d = ext_c;
                    err_d     = ~mem_ack;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
        end
    end

endmodule
